// File: rtl/adder_tree_pipelined_if.sv
// Operand/result bundle for adder_tree_pipelined: one input vector per beat with
// accumulation sideband, one result with status flags.
interface adder_tree_pipelined_if #(
  parameter int NUM_IN = 64,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 18
);
  logic              in_valid;
  logic [IN_W-1:0]   input_matrix [NUM_IN];
  logic              in_acc;
  logic              in_last;
  logic              out_valid;
  logic [OUT_W-1:0]  sum;
  logic              out_sat;
  logic              acc_abort;

  modport master (
    output in_valid, input_matrix, in_acc, in_last,
    input  out_valid, sum, out_sat, acc_abort
  );

  modport slave (
    input  in_valid, input_matrix, in_acc, in_last,
    output out_valid, sum, out_sat, acc_abort
  );
endinterface

// File: rtl/adder_tree_pipelined.sv
// Fully pipelined NUM_IN-to-1 unsigned adder tree with an accumulate/output stage.
// Define ADDER_TREE_SATURATE_EN to clamp the accumulate add and report out_sat.
`ifndef NL_OUT_PHASE_BITWIDTH
`define NL_OUT_PHASE_BITWIDTH 8
`endif

module adder_tree_pipelined #(
  parameter int NUM_IN    = 64,
  parameter int IN_W      = `NL_OUT_PHASE_BITWIDTH,
  parameter int ACC_EXT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  adder_tree_pipelined_if.slave bus
);
  localparam int LEVELS = $clog2(NUM_IN);
  localparam int OUT_W  = IN_W + LEVELS + ACC_EXT_W;
  localparam int TREE_W = IN_W + LEVELS;
  localparam int PADDED = 1 << LEVELS;

  typedef enum logic {IDLE, ACCUM} state_t;

  logic [TREE_W-1:0] leaf [PADDED];
  logic [TREE_W-1:0] tree_sum;
  logic              t_valid;
  logic              t_acc;
  logic              t_last;

  // Operands beyond NUM_IN are zero-padded up to the next power of two.
  for (genvar i = 0; i < PADDED; i++) begin : g_leaf
    if (i < NUM_IN) begin : g_op
      assign leaf[i] = TREE_W'(bus.input_matrix[i]);
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  if (LEVELS == 0) begin : g_bypass
    assign tree_sum = leaf[0];
    assign t_valid  = bus.in_valid;
    assign t_acc    = bus.in_acc;
    assign t_last   = bus.in_last;
  end else begin : g_tree
    typedef struct packed {
      logic valid;
      logic acc;
      logic last;
    } sideband_t;

    // Heap layout: node[1] is the root, node[n] sums children 2n and 2n+1;
    // children at index >= PADDED are the leaves themselves.
    logic [TREE_W-1:0] node  [PADDED];
    logic [TREE_W-1:0] kid_a [PADDED];
    logic [TREE_W-1:0] kid_b [PADDED];
    sideband_t         sb    [LEVELS];

    assign kid_a[0] = '0;
    assign kid_b[0] = '0;
    for (genvar n = 1; n < PADDED; n++) begin : g_kid
      if (2 * n >= PADDED) begin : g_from_leaf
        assign kid_a[n] = leaf[2*n - PADDED];
        assign kid_b[n] = leaf[2*n + 1 - PADDED];
      end else begin : g_from_node
        assign kid_a[n] = node[2*n];
        assign kid_b[n] = node[2*n + 1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        // NOTE: the node array is reset element by element because pipeline data must read 0 after reset.
        for (int n = 0; n < PADDED; n++) node[n] <= '0;
        for (int s = 0; s < LEVELS; s++) sb[s] <= '0;
      end else if (ena) begin
        // NOTE: non-blocking assignments so every level samples the previous level's old value.
        for (int n = 1; n < PADDED; n++) node[n] <= kid_a[n] + kid_b[n];
        sb[0] <= '{valid: bus.in_valid, acc: bus.in_acc, last: bus.in_last};
        for (int s = 1; s < LEVELS; s++) sb[s] <= sb[s-1];
      end
    end

    assign tree_sum = node[1];
    assign t_valid  = sb[LEVELS-1].valid;
    assign t_acc    = sb[LEVELS-1].acc;
    assign t_last   = sb[LEVELS-1].last;
  end

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] sum_q;
  logic             out_valid_q;
  logic             acc_abort_q;
  logic [OUT_W-1:0] tree_ext;
  logic [OUT_W-1:0] acc_sum;
  logic             in_accum;
  logic             grp_mid;
  logic             grp_end;
  logic             plain;

  assign tree_ext = OUT_W'(tree_sum);
  assign in_accum = (state == ACCUM);
  assign grp_mid  = t_valid &  t_acc & ~t_last;
  assign grp_end  = t_valid &  t_acc &  t_last;
  assign plain    = t_valid & ~t_acc;

`ifdef ADDER_TREE_SATURATE_EN
  logic [OUT_W:0] acc_wide;
  logic           acc_ovf;
  logic           sat_sticky;
  logic           out_sat_q;

  assign acc_wide = {1'b0, acc} + {1'b0, tree_ext};
  assign acc_ovf  = acc_wide[OUT_W];
  assign acc_sum  = acc_ovf ? '1 : acc_wide[OUT_W-1:0];

  // A clamp anywhere in the group is remembered until the closing beat reports it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_sticky <= 1'b0;
      out_sat_q  <= 1'b0;
    end else if (ena) begin
      if (grp_mid) sat_sticky <= in_accum & (sat_sticky | acc_ovf);
      if (grp_end) out_sat_q  <= in_accum & (sat_sticky | acc_ovf);
      if (plain) begin
        sat_sticky <= 1'b0;
        out_sat_q  <= 1'b0;
      end
    end
  end

  assign bus.out_sat = out_sat_q;
`else
  assign acc_sum     = acc + tree_ext;
  assign bus.out_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      acc_abort_q <= 1'b0;
    end else if (ena) begin
      out_valid_q <= grp_end | plain;
      if (grp_mid) begin
        acc   <= in_accum ? acc_sum : tree_ext;
        state <= ACCUM;
      end
      if (grp_end) begin
        sum_q       <= in_accum ? acc_sum : tree_ext;
        acc_abort_q <= 1'b0;
        state       <= IDLE;
      end
      // A plain beat inside a group closes it early and discards the partial sum.
      if (plain) begin
        sum_q       <= tree_ext;
        acc_abort_q <= in_accum;
        state       <= IDLE;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.acc_abort = acc_abort_q;

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// Scoreboard bench for adder_tree_pipelined: a default-width DUT and a zero-headroom
// DUT share one directed stimulus stream; a monitor pops and compares each result.
`timescale 1ns/1ps

module tb_adder_tree_pipelined;
  localparam int NUM_IN = 64;
  localparam int IN_W   = 8;
  localparam int LEVELS = 6;
  localparam int OUT_W1 = IN_W + LEVELS + 4;
  localparam int OUT_W2 = IN_W + LEVELS;

`ifdef ADDER_TREE_SATURATE_EN
  localparam int SAT_SUM2  = 16383;
  localparam bit SAT_FLAG2 = 1'b1;
`else
  localparam int SAT_SUM2  = 16256;
  localparam bit SAT_FLAG2 = 1'b0;
`endif

  typedef struct {
    int sum;
    bit abort;
    bit sat;
    int due;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic ena   = 1'b0;

  exp_t q_main[$];
  exp_t q_sat[$];
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;

  always #5 clk = ~clk;

  adder_tree_pipelined_if #(.NUM_IN(NUM_IN), .IN_W(IN_W), .OUT_W(OUT_W1)) bus1 ();
  adder_tree_pipelined_if #(.NUM_IN(NUM_IN), .IN_W(IN_W), .OUT_W(OUT_W2)) bus2 ();

  assign bus2.in_valid     = bus1.in_valid;
  assign bus2.input_matrix = bus1.input_matrix;
  assign bus2.in_acc       = bus1.in_acc;
  assign bus2.in_last      = bus1.in_last;

  adder_tree_pipelined #(.NUM_IN(NUM_IN), .IN_W(IN_W), .ACC_EXT_W(4)) dut_main (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .bus   (bus1.slave)
  );

  adder_tree_pipelined #(.NUM_IN(NUM_IN), .IN_W(IN_W), .ACC_EXT_W(0)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .bus   (bus2.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: an edge counts only when reset is released and ena is high.
  always begin : monitor
    bit   live;
    exp_t e;
    @(posedge clk);
    live = reset && ena;
    if (live) edge_cnt++;
    #1;
    if (live) begin
      if (bus1.out_valid) begin
        if (q_main.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL main_spurious: out_valid with sum=%0d, none expected", bus1.sum);
        end else begin
          e = q_main.pop_front();
          check("main_sum",     64'(bus1.sum),       64'(e.sum));
          check("main_abort",   64'(bus1.acc_abort), 64'(e.abort));
          check("main_sat",     64'(bus1.out_sat),   64'(e.sat));
          check("main_latency", 64'(edge_cnt),       64'(e.due));
        end
      end
      if (bus2.out_valid) begin
        if (q_sat.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sat_spurious: out_valid with sum=%0d, none expected", bus2.sum);
        end else begin
          e = q_sat.pop_front();
          check("sat_sum",     64'(bus2.sum),       64'(e.sum));
          check("sat_abort",   64'(bus2.acc_abort), 64'(e.abort));
          check("sat_sat",     64'(bus2.out_sat),   64'(e.sat));
          check("sat_latency", 64'(edge_cnt),       64'(e.due));
        end
      end
      if (q_main.size() > 0 && q_main[0].due < edge_cnt) begin
        checks++;
        errors++;
        $display("FAIL main_missing: no output by edge %0d, expected sum=%0d", edge_cnt, q_main[0].sum);
        void'(q_main.pop_front());
      end
      if (q_sat.size() > 0 && q_sat[0].due < edge_cnt) begin
        checks++;
        errors++;
        $display("FAIL sat_missing: no output by edge %0d, expected sum=%0d", edge_cnt, q_sat[0].sum);
        void'(q_sat.pop_front());
      end
    end
  end

  task automatic drive_beat(input bit all_ff, input bit acc, input bit last);
    for (int i = 0; i < NUM_IN; i++) bus1.input_matrix[i] = all_ff ? 8'hFF : 8'(i);
    bus1.in_acc   = acc;
    bus1.in_last  = last;
    bus1.in_valid = 1'b1;
  endtask

  // One enabled beat; when push is set the hand-computed results are queued.
  task automatic send(input bit all_ff, input bit acc, input bit last, input bit push,
                      input int s1, input int s2, input bit ab, input bit sat1, input bit sat2);
    @(negedge clk);
    ena = 1'b1;
    drive_beat(all_ff, acc, last);
    if (push) begin
      q_main.push_back(exp_t'{s1, ab, sat1, edge_cnt + 1 + LEVELS});
      q_sat.push_back(exp_t'{s2, ab, sat2, edge_cnt + 1 + LEVELS});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ena           = 1'b1;
      bus1.in_valid = 1'b0;
      bus1.in_acc   = 1'b0;
      bus1.in_last  = 1'b0;
    end
  endtask

  // Frozen cycles carry a would-be group start that must not be captured.
  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      ena = 1'b0;
      drive_beat(1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_main_valid"}, 64'(bus1.out_valid), 64'd0);
    check({tag, "_main_sum"},   64'(bus1.sum),       64'd0);
    check({tag, "_main_sat"},   64'(bus1.out_sat),   64'd0);
    check({tag, "_main_abort"}, 64'(bus1.acc_abort), 64'd0);
    check({tag, "_sat_valid"},  64'(bus2.out_valid), 64'd0);
    check({tag, "_sat_sum"},    64'(bus2.sum),       64'd0);
  endtask

  initial begin
    bus1.in_valid = 1'b0;
    bus1.in_acc   = 1'b0;
    bus1.in_last  = 1'b0;
    for (int i = 0; i < NUM_IN; i++) bus1.input_matrix[i] = '0;

    repeat (2) @(negedge clk);
    check_zero_outputs("reset_state");
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Ramp 0..63 -> 2016
    send(0, 0, 0, 1, 2016, 2016, 0, 0, 0);
    idle(10);

    // Ten back-to-back all-255 beats -> 16320 each
    for (int k = 0; k < 10; k++) send(1, 0, 0, 1, 16320, 16320, 0, 0, 0);
    idle(10);

    // Four-beat ramp group -> 8064, nothing for the first three
    for (int k = 0; k < 3; k++) send(0, 1, 0, 0, 0, 0, 0, 0, 0);
    send(0, 1, 1, 1, 8064, 8064, 0, 0, 0);
    idle(10);

    // One-beat group
    send(0, 1, 1, 1, 2016, 2016, 0, 0, 0);
    idle(3);

    // Two-beat partial group aborted by a plain all-255 beat
    send(0, 1, 0, 0, 0, 0, 0, 0, 0);
    send(0, 1, 0, 0, 0, 0, 0, 0, 0);
    send(1, 0, 0, 1, 16320, 16320, 1, 0, 0);
    idle(3);

    // Stalls with beats in flight; values unchanged, abort cleared
    send(0, 0, 0, 1, 2016, 2016, 0, 0, 0);
    send(1, 0, 0, 1, 16320, 16320, 0, 0, 0);
    stall(3);
    send(0, 0, 0, 1, 2016, 2016, 0, 0, 0);
    idle(2);
    stall(3);
    idle(10);

    // Two all-255 beats accumulated: 32640 fits 18 bits, overflows 14 bits
    send(1, 1, 0, 0, 0, 0, 0, 0, 0);
    send(1, 1, 1, 1, 32640, SAT_SUM2, 0, 0, SAT_FLAG2);
    idle(10);
    send(0, 0, 0, 1, 2016, 2016, 0, 0, 0);
    idle(10);

    // Reset three cycles after a beat: that beat is lost
    send(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    @(negedge clk);
    reset         = 1'b0;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    send(0, 0, 0, 1, 2016, 2016, 0, 0, 0);
    idle(12);

    for (int t = 0; t < 50 && (q_main.size() > 0 || q_sat.size() > 0); t++) idle(1);
    while (q_main.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL main_drain: expected sum=%0d never arrived", q_main[0].sum);
      void'(q_main.pop_front());
    end
    while (q_sat.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL sat_drain: expected sum=%0d never arrived", q_sat[0].sum);
      void'(q_sat.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
